// File: rtl/pipe_out_seq_pkg.sv
// Shared types and helpers for the Pipe Out pattern sequencer.
package pipe_out_seq_pkg;

    // Width of the Pipe Out data word and of the generator output.
    localparam int PIPE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME1 = 3'd1,
        ST_PRIME2 = 3'd2,
        ST_XFER   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A run is in progress in every state except IDLE and DONE.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_PRIME1) || (s == ST_PRIME2) || (s == ST_XFER) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/pipe_out_seq_down_counter.sv
// Loadable down-counter with zero and last-count flags; times the idle gap.
module pipe_out_seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
    assign last = (count_q == ONE);

endmodule

// File: rtl/pipe_out_seq.sv
// Sequencer between the host Pipe Out endpoint and the pattern generator:
// primes the generator, releases data in blocks, inserts idle gaps between
// blocks and flags host reads taken while no data is offered.
module pipe_out_seq
    import pipe_out_seq_pkg::*;
#(
    parameter int BLOCK_W = 10,
    parameter int COUNT_W = 16,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               cfg_mode,
    input  logic [BLOCK_W-1:0] cfg_block_len,
    input  logic [COUNT_W-1:0] cfg_num_blocks,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic               pipe_out_read,
    output logic               pipe_out_ready,
    output logic [15:0]        pipe_out_data,
    output logic               gen_reset,
    output logic               gen_mode,
    output logic               gen_read,
    input  logic [15:0]        gen_data,
    output logic               busy,
    output logic               done,
    output logic               err_cfg,
    output logic               err_underrun,
    output logic [COUNT_W-1:0] blocks_sent
);

    localparam logic [BLOCK_W-1:0] ONE_B = BLOCK_W'(1);
    localparam logic [COUNT_W-1:0] ONE_C = COUNT_W'(1);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] word_cnt_q, word_cnt_d;
    logic [COUNT_W-1:0] blocks_sent_q, blocks_sent_d;
    logic [BLOCK_W-1:0] len_q, len_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               gen_mode_q, gen_mode_d;
    logic               done_q, done_d;
    logic               err_cfg_q, err_cfg_d;
    logic               err_underrun_q, err_underrun_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               gen_reset_q, gen_reset_d;

    logic               gap_load;
    logic               gap_dec;
    logic               gap_zero;
    logic               gap_last;
    logic               block_last;
    logic [COUNT_W-1:0] blocks_inc;

    pipe_out_seq_down_counter #(
        .W (GAP_W)
    ) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_q),
        .dec      (gap_dec),
        .zero     (gap_zero),
        .last     (gap_last)
    );

    // The generator only advances on reads the host was allowed to take.
    assign gen_read      = pipe_out_read & ready_q;
    assign pipe_out_data = gen_data;

    assign block_last = (word_cnt_q == (len_q - ONE_B));
    assign blocks_inc = blocks_sent_q + ONE_C;

    // Next-state, counters, sticky flags and registered outputs.
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        blocks_sent_d  = blocks_sent_q;
        len_d          = len_q;
        num_d          = num_q;
        gap_d          = gap_q;
        gen_mode_d     = gen_mode_q;
        done_d         = done_q;
        err_cfg_d      = err_cfg_q;
        err_underrun_d = err_underrun_q;
        gap_load       = 1'b0;
        gap_dec        = 1'b0;

        if (pipe_out_read && busy_q && !ready_q) begin
            err_underrun_d = 1'b1;
        end

        // Abort wins over everything in a busy state; the generator keeps its state.
        if (abort && state_is_busy(state_q)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        if (cfg_block_len == '0) begin
                            err_cfg_d = 1'b1;
                        end else begin
                            len_d          = cfg_block_len;
                            num_d          = cfg_num_blocks;
                            gap_d          = cfg_gap;
                            gen_mode_d     = cfg_mode;
                            done_d         = 1'b0;
                            err_underrun_d = 1'b0;
                            blocks_sent_d  = '0;
                            word_cnt_d     = '0;
                            state_d        = ST_PRIME1;
                        end
                    end
                end
                ST_PRIME1: state_d = ST_PRIME2;
                ST_PRIME2: state_d = ST_XFER;
                ST_XFER: begin
                    if (gen_read) begin
                        if (block_last) begin
                            word_cnt_d    = '0;
                            blocks_sent_d = blocks_inc;
                            if ((num_q != '0) && (blocks_inc == num_q)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else if (gap_q != '0) begin
                                state_d  = ST_GAP;
                                gap_load = 1'b1;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + ONE_B;
                        end
                    end
                end
                ST_GAP: begin
                    // The zero check only guards against a stuck gap; normal exit is at count 1.
                    if (gap_last || gap_zero) begin
                        state_d = ST_XFER;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ready_d     = (state_d == ST_XFER);
        busy_d      = state_is_busy(state_d);
        gen_reset_d = (state_d == ST_PRIME1);
    end

    // Control state and flags; the generator is held in reset while reset is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= '0;
            blocks_sent_q  <= '0;
            gen_mode_q     <= 1'b0;
            done_q         <= 1'b0;
            err_cfg_q      <= 1'b0;
            err_underrun_q <= 1'b0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            gen_reset_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            blocks_sent_q  <= blocks_sent_d;
            gen_mode_q     <= gen_mode_d;
            done_q         <= done_d;
            err_cfg_q      <= err_cfg_d;
            err_underrun_q <= err_underrun_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            gen_reset_q    <= gen_reset_d;
        end
    end

    // Run configuration captured at start; only read while a run is active.
    always_ff @(posedge clk) begin
        len_q <= len_d;
        num_q <= num_d;
        gap_q <= gap_d;
    end

    assign pipe_out_ready = ready_q;
    assign gen_reset      = gen_reset_q;
    assign gen_mode       = gen_mode_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cfg        = err_cfg_q;
    assign err_underrun   = err_underrun_q;
    assign blocks_sent    = blocks_sent_q;

endmodule

// File: tb/tb_pipe_out_seq.sv
// Directed bench for pipe_out_seq with a behavioural pattern generator and a
// scoreboard of expected Pipe Out words.
`timescale 1ns/1ps
module tb_pipe_out_seq;

    localparam int BLOCK_W = 10;
    localparam int COUNT_W = 16;
    localparam int GAP_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic               cfg_mode;
    logic [BLOCK_W-1:0] cfg_block_len;
    logic [COUNT_W-1:0] cfg_num_blocks;
    logic [GAP_W-1:0]   cfg_gap;
    logic               pipe_out_read;
    logic               pipe_out_ready;
    logic [15:0]        pipe_out_data;
    logic               gen_reset;
    logic               gen_mode;
    logic               gen_read;
    logic [15:0]        gen_data;
    logic               busy;
    logic               done;
    logic               err_cfg;
    logic               err_underrun;
    logic [COUNT_W-1:0] blocks_sent;

    logic [15:0]        gen_q;
    logic               gen_mode_lat;

    int                 total = 0;
    int                 bad   = 0;
    logic [15:0]        sb[$];

    always #5 clk = ~clk;

    pipe_out_seq #(
        .BLOCK_W (BLOCK_W),
        .COUNT_W (COUNT_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_mode       (cfg_mode),
        .cfg_block_len  (cfg_block_len),
        .cfg_num_blocks (cfg_num_blocks),
        .cfg_gap        (cfg_gap),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_ready (pipe_out_ready),
        .pipe_out_data  (pipe_out_data),
        .gen_reset      (gen_reset),
        .gen_mode       (gen_mode),
        .gen_read       (gen_read),
        .gen_data       (gen_data),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_underrun   (err_underrun),
        .blocks_sent    (blocks_sent)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] d);
        return {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
    endfunction

    // Pattern generator: seeded on gen_reset, advanced on gen_read.
    always @(posedge clk) begin
        if (gen_reset) begin
            gen_q        <= gen_mode ? 16'h0201 : 16'h0001;
            gen_mode_lat <= gen_mode;
        end else if (gen_read) begin
            gen_q <= gen_mode_lat ? lfsr_next(gen_q) : gen_q + 16'd1;
        end
    end
    assign gen_data = gen_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; every accepted read pops and checks one scoreboard word.
    task automatic cyc(input int n);
        logic [15:0] exp_w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gen_read) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL sb_extra_read: observed=0x%0h expected=none", pipe_out_data);
                end else begin
                    exp_w = sb.pop_front();
                    chk("data", {16'h0, pipe_out_data}, {16'h0, exp_w});
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic m, input int len, input int num, input int gap);
        cfg_mode       = m;
        cfg_block_len  = BLOCK_W'(len);
        cfg_num_blocks = COUNT_W'(num);
        cfg_gap        = GAP_W'(gap);
        start          = 1'b1;
        cyc(1);
        start          = 1'b0;
    endtask

    task automatic push_count(input int first, input int n);
        for (int i = 0; i < n; i++) sb.push_back(16'(first + i));
    endtask

    task automatic push_lfsr(input int n);
        logic [15:0] v;
        v = 16'h0201;
        for (int i = 0; i < n; i++) begin
            sb.push_back(v);
            v = lfsr_next(v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; pipe_out_read = 1'b0;
        cfg_mode = 1'b0; cfg_block_len = '0; cfg_num_blocks = '0; cfg_gap = '0;
        cyc(3);
        chk("rst_gen_reset", gen_reset, 1);
        chk("rst_ready", pipe_out_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cfg", err_cfg, 0);
        chk("rst_err_underrun", err_underrun, 0);
        chk("rst_blocks", blocks_sent, 0);
        chk("rst_gen_mode", gen_mode, 0);
        reset = 1'b0;
        cyc(1);
        chk("idle_gen_reset", gen_reset, 0);

        // Test 1: LFSR, 2 blocks of 4, gap 3, host reading continuously.
        push_lfsr(8);
        do_start(1'b1, 4, 2, 3);
        chk("t1_prime1_gen_reset", gen_reset, 1);
        chk("t1_prime1_busy", busy, 1);
        chk("t1_prime1_ready", pipe_out_ready, 0);
        chk("t1_gen_mode", gen_mode, 1);
        cyc(1);
        chk("t1_prime2_gen_reset", gen_reset, 0);
        chk("t1_prime2_ready", pipe_out_ready, 0);
        cyc(1);
        pipe_out_read = 1'b1;
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("t1_ready_c%0d", c), pipe_out_ready,
                ((c < 4) || (c >= 7)) ? 1 : 0);
            cyc(1);
        end
        pipe_out_read = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ready_end", pipe_out_ready, 0);
        chk("t1_blocks", blocks_sent, 2);
        chk("t1_underrun_gap", err_underrun, 1);
        chk("t1_sb_drained", sb.size(), 0);

        // Test 2: count mode, continuous blocks of 3, no gap.
        do_start(1'b0, 3, 0, 0);
        chk("t2_done_cleared", done, 0);
        chk("t2_underrun_cleared", err_underrun, 0);
        chk("t2_blocks_cleared", blocks_sent, 0);
        chk("t2_gen_mode", gen_mode, 0);
        push_count(1, 9);
        cyc(2);
        pipe_out_read = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t2_ready_%0d", i), pipe_out_ready, 1);
            cyc(1);
        end
        pipe_out_read = 1'b0;
        chk("t2_blocks", blocks_sent, 3);
        chk("t2_busy", busy, 1);
        chk("t2_ready", pipe_out_ready, 1);
        chk("t2_sb_drained", sb.size(), 0);

        // Start while busy is ignored; then abort mid-block.
        push_count(10, 2);
        cfg_mode = 1'b1; cfg_block_len = 10'd4;
        start = 1'b1; pipe_out_read = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t4_busy_start_gen_reset", gen_reset, 0);
        chk("t4_busy_start_busy", busy, 1);
        chk("t4_busy_start_mode", gen_mode, 0);
        cyc(1);
        pipe_out_read = 1'b0;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_ready", pipe_out_ready, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_gen_reset", gen_reset, 0);
        chk("t4_sb_drained", sb.size(), 0);
        pipe_out_read = 1'b1;
        cyc(1);
        pipe_out_read = 1'b0;
        chk("t4_idle_read_no_underrun", err_underrun, 0);

        // Restart re-primes from the seed; reads during PRIME flag underrun.
        push_lfsr(4);
        pipe_out_read = 1'b1;
        do_start(1'b1, 4, 1, 0);
        chk("t3_prime1_gen_reset", gen_reset, 1);
        chk("t3_prime1_underrun", err_underrun, 0);
        cyc(1);
        chk("t3_prime2_underrun", err_underrun, 1);
        chk("t3_prime2_gen_read", gen_read, 0);
        cyc(1);
        chk("t3_xfer_ready", pipe_out_ready, 1);
        cyc(4);
        pipe_out_read = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_blocks", blocks_sent, 1);
        chk("t3_busy", busy, 0);
        chk("t3_sb_drained", sb.size(), 0);

        // Test 5: zero length rejected; start with abort in the same cycle ignored.
        do_start(1'b0, 0, 1, 0);
        chk("t5_err_cfg", err_cfg, 1);
        chk("t5_busy", busy, 0);
        chk("t5_gen_reset", gen_reset, 0);
        chk("t5_done_kept", done, 1);
        cfg_block_len = 10'd4;
        start = 1'b1; abort = 1'b1;
        cyc(1);
        start = 1'b0; abort = 1'b0;
        chk("t5_sa_busy", busy, 0);
        chk("t5_sa_gen_reset", gen_reset, 0);
        chk("t5_sa_done", done, 1);

        // Test 6: reset during XFER.
        push_count(1, 2);
        do_start(1'b0, 5, 0, 2);
        cyc(2);
        pipe_out_read = 1'b1;
        cyc(2);
        pipe_out_read = 1'b0;
        reset = 1'b1;
        cyc(1);
        chk("t6_ready", pipe_out_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err_cfg", err_cfg, 0);
        chk("t6_err_underrun", err_underrun, 0);
        chk("t6_blocks", blocks_sent, 0);
        chk("t6_gen_reset", gen_reset, 1);
        cyc(1);
        chk("t6_gen_reset_held", gen_reset, 1);
        reset = 1'b0;
        cyc(1);
        chk("t6_gen_reset_release", gen_reset, 0);
        chk("t6_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
